prog_seq: RTL and testbench
===========================

# prog_seq

Program sequencer that launches the processor's programs and enables/loads the program counter. Sits between the top-level test harness (Start/ProgSel) and the program counter: it forces the PC to the selected program's base address, enables fetch while the program runs, and watches the decoder's halt indication. It reports completion, a timeout, and a cycle count of the last run.

## Interface
Parameters:
- L, 10: PC / address width.
- CW, 16: cycle-counter width.
- BASE0, 0: start address of program 0 (L bits).
- BASE1, 128: start address of program 1.
- BASE2, 256: start address of program 2.
- TIMEOUT, 4000: maximum RUN cycles before abort; must satisfy 1 ≤ TIMEOUT < 2^CW.

Ports. One clock; reset is asynchronous and active-high (Clk, Reset):
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values.
- Start  in  1  request to launch a program; sampled only in IDLE.
- ProgSel  in  2  program index captured with Start; valid values 0..2.
- Halt  in  1  decoder flags halt instruction in current cycle; sampled only in RUN.
- PcInit  out  1  force PC load of StartAddr this cycle.
- StartAddr  out  L  registered base address of the selected program.
- PcEn  out  1  PC may advance/jump (fetch enabled).
- Busy  out  1  program in flight (LOAD, RUN, DONE).
- Done  out  1  one-cycle pulse at end of program.
- Timeout  out  1  sticky: last run aborted by TIMEOUT; cleared at next LOAD.
- CycleCnt  out  CW  RUN cycles of current/last run; holds after DONE.

## Operation
- States: IDLE, LOAD, RUN, DONE. Encoded state register, async reset to IDLE.
- IDLE: PcInit=0, PcEn=0, Busy=0, Done=0. If Start=1 and ProgSel≤2, capture StartAddr=BASE[ProgSel] and go to LOAD. If ProgSel=3, the request is ignored and the state stays IDLE.
- LOAD (exactly 1 cycle): PcInit=1, PcEn=0, Busy=1; CycleCnt←0, Timeout←0. The next state is RUN.
- RUN: PcEn=1, Busy=1, PcInit=0. CycleCnt←CycleCnt+1 every RUN cycle, including the exit cycle.
  - Halt=1 → go to DONE; Timeout stays 0.
  - Halt=0 and CycleCnt+1==TIMEOUT → Timeout←1, go to DONE.
  - Otherwise stay in RUN.
- DONE (exactly 1 cycle): Done=1, Busy=1, PcEn=0. The next state is IDLE.
- Outputs PcInit, PcEn, Busy and Done decode from the current state only (Moore). StartAddr, CycleCnt and Timeout are registers.
- Arithmetic: CycleCnt is an unsigned CW-bit value. It cannot wrap because TIMEOUT < 2^CW.

## Timing
- Reset values: state=IDLE, PcInit=0, PcEn=0, Busy=0, Done=0, Timeout=0, CycleCnt=0, StartAddr=0. Reset takes effect immediately and asynchronously; deassertion is synchronous to Clk.
- Latency: Start sampled at edge n → PcInit high in cycle n+1 → PcEn high from cycle n+2.
- Run timing: the first PC advance happens on the edge ending the first RUN cycle. Halt sampled at edge m → Done high in cycle m+1 → IDLE at m+2. The earliest next Start is accepted at edge m+2.
- Start while Busy=1 is ignored and is not queued.
- Halt outside RUN is ignored.
- Halt and the timeout condition in the same cycle: Halt wins, Timeout=0, CycleCnt=TIMEOUT.
- Halt in the first RUN cycle gives CycleCnt=1.
- Reset mid-run aborts the run with no Done pulse, and CycleCnt clears.
- StartAddr stays stable from LOAD until the next accepted Start.

## Test plan
- Reset then idle: assert Reset asynchronously mid-cycle → all outputs 0 immediately; Start=0 for 10 cycles → Busy stays 0.
- Program 1 launch: Start=1, ProgSel=1 → next cycle PcInit=1, StartAddr=128; then PcEn=1. Halt after 5 RUN cycles → Done pulse one cycle, CycleCnt=5, Timeout=0, Busy low the following cycle.
- Invalid and overlapping requests: Start with ProgSel=3 → no state change. Start with ProgSel=2 during RUN → ignored, StartAddr stays at the value of the current run.
- Timeout: TIMEOUT=8, ProgSel=0, no Halt → after 8 RUN cycles Done=1, Timeout=1, CycleCnt=8. Next launch → Timeout cleared in LOAD.
- Simultaneous Halt and timeout: TIMEOUT=8, Halt on the 8th RUN cycle → Timeout=0, CycleCnt=8, Done=1.
- Reset mid-run: Reset during RUN cycle 3 → IDLE, PcEn=0, no Done, CycleCnt=0. Immediate relaunch with ProgSel=0 works normally (StartAddr=0, Halt at cycle 2 → CycleCnt=2).

Source files
------------

// File: rtl/prog_seq_if.sv
// Handshake bundle between the test harness / decoder and the program sequencer.
interface prog_seq_if #(
  parameter int unsigned L  = 10,
  parameter int unsigned CW = 16
);
  logic          start;
  logic [1:0]    prog_sel;
  logic          halt;
  logic          pc_init;
  logic [L-1:0]  start_addr;
  logic          pc_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;

  // Harness/decoder side: requests launches and flags halt.
  modport master (
    output start, prog_sel, halt,
    input  pc_init, start_addr, pc_en, busy, done, timeout, cycle_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, prog_sel, halt,
    output pc_init, start_addr, pc_en, busy, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/prog_seq.sv
// Program sequencer: loads the PC with the selected program base, enables fetch while the
// program runs, and ends the run on halt or after TIMEOUT run cycles.
module prog_seq #(
  parameter int unsigned L       = 10,
  parameter int unsigned CW      = 16,
  parameter int unsigned BASE0   = 0,
  parameter int unsigned BASE1   = 128,
  parameter int unsigned BASE2   = 256,
  parameter int unsigned TIMEOUT = 4000
) (
  input logic       clk_i,
  input logic       rst_i,
  prog_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);

  state_e        state_q;
  logic          pc_init_q;
  logic          pc_en_q;
  logic          busy_q;
  logic          done_q;
  logic          timeout_q;
  logic [L-1:0]  start_addr_q;
  logic [CW-1:0] cycle_cnt_q;

  logic [L-1:0]  base_sel;
  logic [CW-1:0] cnt_inc;

  // Base address lookup for the requested program; index 3 is never used (rejected in idle).
  always_comb begin
    base_sel = L'(BASE0);
    case (bus.prog_sel)
      2'd1:    base_sel = L'(BASE1);
      2'd2:    base_sel = L'(BASE2);
      default: base_sel = L'(BASE0);
    endcase
  end

  assign cnt_inc = cycle_cnt_q + CW'(1);

  // Sequencer FSM; the Moore outputs are registered from the next state so they track state_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pc_init_q    <= 1'b0;
      pc_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      start_addr_q <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start && (bus.prog_sel != 2'd3)) begin
            start_addr_q <= base_sel;
            state_q      <= StLoad;
            pc_init_q    <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StLoad: begin
          cycle_cnt_q <= '0;
          timeout_q   <= 1'b0;
          state_q     <= StRun;
          pc_init_q   <= 1'b0;
          pc_en_q     <= 1'b1;
        end
        StRun: begin
          cycle_cnt_q <= cnt_inc;
          if (bus.halt) begin
            state_q <= StDone;
            pc_en_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (cnt_inc == TimeoutCnt) begin
            // Halt takes priority, so timeout is only flagged when halt is absent.
            timeout_q <= 1'b1;
            state_q   <= StDone;
            pc_en_q   <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          pc_init_q <= 1'b0;
          pc_en_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_init    = pc_init_q;
  assign bus.start_addr = start_addr_q;
  assign bus.pc_en      = pc_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_prog_seq.sv
// Randomised bench for prog_seq: each launch is predicted at transaction level (run length,
// timeout flag, base address) and every cycle of the run is checked against that prediction.
module tb_prog_seq;

  localparam int unsigned L  = 10;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 8;

  logic clk;
  logic rst;

  prog_seq_if #(.L(L), .CW(CW)) bus ();

  prog_seq #(
    .L(L), .CW(CW), .BASE0(0), .BASE1(128), .BASE2(256), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state carried between launches.
  int exp_addr = 0;
  int exp_cnt  = 0;
  int exp_to   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int base_of(input int sel);
    case (sel)
      1:       return 128;
      2:       return 256;
      default: return 0;
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},    32'(bus.busy), 0);
    chk({tag, ".pc_init"}, 32'(bus.pc_init), 0);
    chk({tag, ".pc_en"},   32'(bus.pc_en), 0);
    chk({tag, ".done"},    32'(bus.done), 0);
    chk({tag, ".addr"},    32'(bus.start_addr), exp_addr);
    chk({tag, ".cnt"},     32'(bus.cycle_cnt), exp_cnt);
    chk({tag, ".to"},      32'(bus.timeout), exp_to);
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear before any edge.
  task automatic mid_cycle_reset();
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_addr = 0;
    exp_cnt  = 0;
    exp_to   = 0;
    chk_idle("async_rst");
    #1 rst = 1'b0;
    tick();
    chk_idle("post_rst");
  endtask

  // One launch request. halt_at=0 means no halt; abort_at>0 resets in that RUN cycle.
  task automatic run_prog(input int sel, input int halt_at, input int abort_at, input bit noise);
    int len;
    int to;
    bus.start    = 1'b1;
    bus.prog_sel = 2'(sel);
    bus.halt     = 1'($urandom_range(0, 1));  // halt outside RUN must be ignored
    tick();
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    if (sel == 3) begin
      chk_idle("sel3");
      return;
    end
    if (halt_at == 0 || halt_at > int'(TO)) begin
      len = TO;
      to  = 1;
    end else begin
      len = halt_at;
      to  = 0;
    end
    exp_addr = base_of(sel);
    chk("load.pc_init", 32'(bus.pc_init), 1);
    chk("load.pc_en",   32'(bus.pc_en), 0);
    chk("load.busy",    32'(bus.busy), 1);
    chk("load.done",    32'(bus.done), 0);
    chk("load.addr",    32'(bus.start_addr), exp_addr);
    tick();
    for (int k = 1; k <= len; k++) begin
      chk("run.pc_en",   32'(bus.pc_en), 1);
      chk("run.pc_init", 32'(bus.pc_init), 0);
      chk("run.busy",    32'(bus.busy), 1);
      chk("run.done",    32'(bus.done), 0);
      chk("run.cnt",     32'(bus.cycle_cnt), k - 1);
      chk("run.to",      32'(bus.timeout), 0);
      chk("run.addr",    32'(bus.start_addr), exp_addr);
      if (k == abort_at) begin
        mid_cycle_reset();
        return;
      end
      bus.halt     = (k == halt_at);
      bus.start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.prog_sel = 2'($urandom_range(0, 3));
      tick();
    end
    exp_cnt = len;
    exp_to  = to;
    chk("done.done",  32'(bus.done), 1);
    chk("done.busy",  32'(bus.busy), 1);
    chk("done.pc_en", 32'(bus.pc_en), 0);
    chk("done.cnt",   32'(bus.cycle_cnt), exp_cnt);
    chk("done.to",    32'(bus.timeout), exp_to);
    chk("done.addr",  32'(bus.start_addr), exp_addr);
    bus.halt     = 1'($urandom_range(0, 1));
    bus.start    = noise ? 1'b1 : 1'b0;
    bus.prog_sel = 2'($urandom_range(0, 2));
    tick();
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    chk_idle("after_done");
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.prog_sel = 2'd0;
    bus.halt     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle("reset");

    // Idle with no request; stray halts ignored.
    for (int i = 0; i < 10; i++) begin
      bus.halt = 1'($urandom_range(0, 1));
      tick();
      chk("idle.busy", 32'(bus.busy), 0);
    end
    bus.halt = 1'b0;
    mid_cycle_reset();

    run_prog(1, 5, 0, 1'b0);  // program 1, halt after 5 RUN cycles
    run_prog(3, 0, 0, 1'b0);  // invalid index ignored
    run_prog(1, 4, 0, 1'b1);  // program 2 requests during the run are ignored
    run_prog(0, 0, 0, 1'b0);  // timeout
    chk("to.sticky", 32'(bus.timeout), 1);
    run_prog(2, 3, 0, 1'b0);  // timeout cleared by next launch
    run_prog(0, 8, 0, 1'b0);  // halt coincides with timeout
    run_prog(1, 1, 0, 1'b0);  // halt in first RUN cycle
    run_prog(2, 0, 3, 1'b0);  // reset during RUN cycle 3
    run_prog(0, 2, 0, 1'b0);  // immediate relaunch

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.halt = 1'($urandom_range(0, 1));
        tick();
        chk("gap.busy", 32'(bus.busy), 0);
      end
      run_prog($urandom_range(0, 3), $urandom_range(0, 10),
               ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0,
               1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
